// File: rtl/sub_serial_pkg.sv
// Shared constants for the bit-serial subtractor (state encoding, default masks).
// Latency: n/a (constants only).
// Backpressure: n/a.
package sub_serial_pkg;

  // FSM state encoding, shared with the serial adder's control flow
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] SUB   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Default per-bit inversion masks, identical to the serial adder's
  localparam logic [7:0] A_MASK_DEF = 8'h6A;
  localparam logic [7:0] B_MASK_DEF = 8'hB2;

endpackage

// File: rtl/sub_serial_bitcell.sv
// One-bit full subtractor: diff = s - b - bin, bout = borrow out.
// Latency: purely combinational.
// Backpressure: none.
module sub_serial_bitcell
  import sub_serial_pkg::*;
(
  input  logic s,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = s ^ b ^ bin;
  assign bout = (~s & b) | (~s & bin) | (b & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor recovering A = sum - B, LSB first; masks applied when SUB_SERIAL_SCRAMBLE_EN is defined.
// Latency: done/out valid DELAY_CYCLES+WIDTH edges after the IDLE+en edge.
// Backpressure: en starts an op in IDLE and acknowledges in DONE; en is ignored elsewhere.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      DELAY_CYCLES = 1,
  parameter logic [WIDTH-1:0] A_MASK       = WIDTH'(A_MASK_DEF),
  parameter logic [WIDTH-1:0] B_MASK       = WIDTH'(B_MASK_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             done
);

`ifdef SUB_SERIAL_SCRAMBLE_EN
  localparam bit SCRAMBLE = 1'b1;
`else
  localparam bit SCRAMBLE = 1'b0;
`endif

  // Without scrambling the masks collapse to zero, leaving a plain subtraction
  localparam logic [WIDTH-1:0] A_MASK_EFF = SCRAMBLE ? A_MASK : '0;
  localparam logic [WIDTH-1:0] B_MASK_EFF = SCRAMBLE ? B_MASK : '0;

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned DW = $clog2(DELAY_CYCLES + 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] s_q,      s_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] d_q,      d_d;
  logic [WIDTH-1:0] out_q,    out_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [DW-1:0]    dly_q,    dly_d;

  logic             diff;
  logic             bout;
  logic [WIDTH-1:0] d_next;

  sub_serial_bitcell u_bitcell (
    .s    (s_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .diff (diff),
    .bout (bout)
  );

  // Partial difference after shifting in this cycle's bit at the MSB
  assign d_next = {diff, d_q[WIDTH-1:1]};

  // Next-state and datapath update for IDLE/DELAY/SUB/DONE
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    b_d      = b_q;
    d_d      = d_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    dly_d    = dly_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          s_d      = sum;
          b_d      = b ^ B_MASK_EFF;
          d_d      = '0;
          borrow_d = 1'b0;
          count_d  = '0;
          dly_d    = '0;
          out_d    = '0;
          state_d  = DELAY;
        end
      end
      DELAY: begin
        dly_d = dly_q + DW'(1);
        if (dly_q == DW'(DELAY_CYCLES - 1)) begin
          state_d = SUB;
        end
      end
      SUB: begin
        borrow_d = bout;
        s_d      = s_q >> 1;
        b_d      = b_q >> 1;
        d_d      = d_next;
        count_d  = count_q + CW'(1);
        // Result appears only on the final bit, so no partial value leaks out
        if (count_q == CW'(WIDTH - 1)) begin
          out_d   = d_next ^ A_MASK_EFF;
          state_d = DONE;
        end
      end
      default: begin
        // DONE: hold the result until en acknowledges it
        if (en) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      dly_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      b_q      <= b_d;
      d_q      <= d_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      dly_q    <= dly_d;
    end
  end

  assign out  = out_q;
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: reset, plain/scrambled results, wrap, async reset, ignored en, latency sweep.
// Latency: checks done at DELAY_CYCLES+WIDTH edges for two parameter sets.
// Backpressure: exercises en start in IDLE and acknowledge in DONE.
module tb_sub_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en,   en3;
  logic [7:0] sum,  sum3;
  logic [7:0] b,    b3;
  logic [7:0] out,  out3;
  logic       done, done3;

  int errors = 0;
  int checks = 0;

`ifdef SUB_SERIAL_SCRAMBLE_EN
  localparam logic [7:0] EXP_5C   = 8'hDD;
  localparam logic [7:0] EXP_WRAP = 8'h27;
  localparam logic [7:0] EXP_10   = 8'h37;
`else
  localparam logic [7:0] EXP_5C   = 8'h45;
  localparam logic [7:0] EXP_WRAP = 8'hFF;
  localparam logic [7:0] EXP_10   = 8'h0F;
`endif

  always #5 clk = ~clk;

  sub_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sum   (sum),
    .b     (b),
    .out   (out),
    .done  (done)
  );

  sub_serial #(.DELAY_CYCLES(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en3),
    .sum   (sum3),
    .b     (b3),
    .out   (out3),
    .done  (done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [7:0] s, input logic [7:0] bb,
                        input logic [7:0] exp, input bit noisy);
    int lat;
    bit partial;
    sum = s;
    b   = bb;
    en  = 1'b1;
    step();
    en      = 1'b0;
    lat     = 0;
    partial = 1'b0;
    while (!done && lat < 40) begin
      if (out !== 8'h00) partial = 1'b1;
      if (noisy) begin
        en  = 1'($urandom_range(0, 1));
        sum = 8'($urandom);
        b   = 8'($urandom);
      end
      step();
      lat++;
    end
    en = 1'b0;
    check({tag, " latency"}, lat, 9);
    check({tag, " out"}, out, exp);
    check({tag, " no partial"}, partial, 0);
  endtask

  initial begin
    int lat3;
    rst_n = 1'b0;
    en    = 1'b0;
    sum   = 8'h00;
    b     = 8'h00;
    en3   = 1'b0;
    sum3  = 8'h00;
    b3    = 8'h00;

    #23;
    check("reset out", out, 0);
    check("reset done", done, 0);
    check("reset state", dut.state_q, 0);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("idle out", out, 0);
    check("idle done", done, 0);
    check("idle state", dut.state_q, 0);

    // Basic subtraction and DONE handshake
    run_op("basic", 8'h5C, 8'h17, EXP_5C, 1'b0);
    repeat (3) step();
    check("done hold", done, 1);
    check("done out hold", out, EXP_5C);
    en = 1'b1;
    step();
    en = 1'b0;
    check("ack done low", done, 0);
    check("ack out held", out, EXP_5C);
    check("ack state idle", dut.state_q, 0);
    repeat (3) step();
    check("no restart", dut.state_q, 0);

    // Underflow wraps modulo 2^8
    run_op("wrap", 8'h00, 8'h01, EXP_WRAP, 1'b0);

    // Asynchronous reset while holding a result in DONE
    #3;
    rst_n = 1'b0;
    #1;
    check("arst done out", out, 0);
    check("arst done done", done, 0);
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset during the 4th SUB cycle
    sum = 8'h5C;
    b   = 8'h17;
    en  = 1'b1;
    step();
    en = 1'b0;
    step();
    repeat (3) step();
    check("mid sub state", dut.state_q, 2);
    check("mid sub count", dut.count_q, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst sub state", dut.state_q, 0);
    check("arst sub count", dut.count_q, 0);
    check("arst sub dreg", dut.d_q, 0);
    check("arst sub out", out, 0);
    check("arst sub done", done, 0);
    step();
    rst_n = 1'b1;
    step();

    run_op("post reset", 8'h10, 8'h01, EXP_10, 1'b0);
    en = 1'b1;
    step();
    en = 1'b0;
    check("ack2 state idle", dut.state_q, 0);

    // en and operands toggling during DELAY/SUB must not disturb the result
    run_op("noisy", 8'h5C, 8'h17, EXP_5C, 1'b1);

    // Longer delay: latency DELAY_CYCLES+WIDTH = 11
    sum3 = 8'h5C;
    b3   = 8'h17;
    en3  = 1'b1;
    step();
    en3  = 1'b0;
    lat3 = 0;
    while (!done3 && lat3 < 40) begin
      step();
      lat3++;
    end
    check("delay3 latency", lat3, 11);
    check("delay3 out", out3, EXP_5C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial subtractor that inverts the team's serial adder: given a sum word and the B operand, it recovers the A operand, LSB first, one bit per clock. With scrambling compiled in, it applies the same fixed per-bit inversion masks as the adder, so a round trip returns the original A. It sits on the receive side of the obfuscated arithmetic path and uses the same en-driven IDLE/DELAY/compute/DONE control flow as the adder.

## Interface
- `WIDTH`, 8: operand width in bits; must be ≥ 2.
- `DELAY_CYCLES`, 1: number of cycles spent in the obfuscation delay state before subtraction starts; must be ≥ 1.
- `A_MASK`, 8'h6A: inversion mask applied to recovered A (bits 6, 5, 3, 1); WIDTH bits.
- `B_MASK`, 8'hB2: inversion mask applied to B on load (bits 7, 5, 4, 1); WIDTH bits.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: start in IDLE; acknowledge/release in DONE.
- `sum` input WIDTH: sum word, sampled only on the IDLE+en edge.
- `b` input WIDTH: B operand (unscrambled form), sampled only on the IDLE+en edge.
- `out` output WIDTH: recovered A; registered.
- `done` output 1: high while in DONE; registered/decoded from state.

## Operation
- State machine: IDLE → DELAY → SUB → DONE → IDLE. 2-bit state.
- IDLE: when en=1, load `s_reg=sum`, `b_reg=b^B_MASK`, `d_reg=0`, `borrow=0`, `count=0`, `dly=0`, `out=0`, and go to DELAY. When en=0, stay in IDLE with all registers held.
- DELAY: `dly` increments each cycle; on the cycle where `dly==DELAY_CYCLES-1`, go to SUB. Datapath registers hold.
- SUB, per cycle:
  - `diff = s_reg[0]^b_reg[0]^borrow`
  - `borrow <= (~s_reg[0]&b_reg[0]) | (~s_reg[0]&borrow) | (b_reg[0]&borrow)`
  - `s_reg`, `b_reg` shift right by 1
  - `d_reg <= {diff, d_reg[WIDTH-1:1]}`
  - `count++`
- Last SUB cycle (`count==WIDTH-1`): load `out <= {diff, d_reg[WIDTH-1:1]} ^ A_MASK` and go to DONE.
- DONE: `out` and `done` hold. en=1 moves to IDLE on the next edge; that edge does not start a new operation. en=0 stays in DONE.
- Arithmetic is modulo 2^WIDTH. The final borrow is discarded, so underflow wraps silently.
- en in DELAY or SUB is ignored; inputs may change freely outside the IDLE+en edge.

## Timing
- Reset (rst_n=0, any time, including mid-SUB): state=IDLE; out, done, s_reg, b_reg, d_reg, borrow, count, dly all 0. This takes effect immediately and asynchronously.
- en sampled high in IDLE at edge k: done rises after edge k+DELAY_CYCLES+WIDTH (9 cycles at defaults). `out` is valid from the same edge.
- `out` reads 0 from the start edge until the final SUB edge; no partial results are visible.
- Minimum start-to-start period: DELAY_CYCLES+WIDTH+2 edges (DONE→IDLE, then IDLE+en).

## Configuration
- `SUB_SERIAL_SCRAMBLE_EN` defined: B_MASK is applied on load and A_MASK is applied on the final `out` load, as described above.
- Not defined: both masks are treated as 0, giving a plain `out = sum - b mod 2^WIDTH`. All timing and states are identical.

## Structure
- Package `sub_serial_pkg` holds:
  - state encoding constants IDLE=0, DELAY=1, SUB=2, DONE=3;
  - default mask constants 8'h6A and 8'hB2.
- Sub-module `sub_serial_bitcell`: purely combinational full subtractor (inputs s, b, bin; outputs diff, bout), instantiated once in the SUB datapath.
- Top module holds the FSM, counters and shift registers.

## Test plan
- Reset values: hold rst_n=0, then release → out=0, done=0, state IDLE. en=0 for 20 cycles → no change.
- Plain subtraction (macro undefined): sum=8'h5C, b=8'h17, en pulse → done rises exactly 9 cycles later with out=8'h45. en=1 in DONE → back to IDLE, out held.
- Scrambled round trip (macro defined): sum=8'h5C, b=8'h17 → out=8'hDD. Feeding a=8'hDD, b=8'h17 through the serial adder yields 8'h5C.
- Wrap-around (plain): sum=8'h00, b=8'h01 → out=8'hFF, done asserted normally.
- Reset mid-operation: assert rst_n=0 during the 4th SUB cycle → outputs drop to 0 immediately. After release, a new run with sum=8'h10, b=8'h01 (plain) → out=8'h0F.
- Ignored en and parameter sweep: toggle en and change sum/b during DELAY and SUB → result unchanged. With DELAY_CYCLES=3, WIDTH=8 → done latency 11 cycles.
